// File: rtl/mux_stream_rr.sv
// N-to-1 registered stream multiplexer with valid/ready on every channel.
// Round-robin or fixed-priority arbitration feeding a single output register.
module mux_stream_rr #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned RR_MODE    = 1,
  parameter int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_sel,
  input  logic                         out_ready
);

  localparam int unsigned LAST_CH = NUM_CH - 1;

  logic [SEL_W-1:0]      rr_ptr;
  logic [SEL_W-1:0]      ptr_eff;
  logic [NUM_CH-1:0]     hi_mask;
  logic                  any_lo;
  logic                  any_hi;
  logic [SEL_W-1:0]      idx_lo;
  logic [SEL_W-1:0]      idx_hi;
  logic                  grant_vld;
  logic [SEL_W-1:0]      grant_idx;
  logic [NUM_CH-1:0]     grant_oh;
  logic                  load_en;
  logic                  in_xfer;
  logic [SEL_W-1:0]      ptr_next;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

  // Unpack the flat input bus into per-channel words.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fixed priority is round-robin with the pointer pinned at channel 0.
  assign ptr_eff = (RR_MODE != 0) ? rr_ptr : '0;

  always_comb begin
    hi_mask = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      hi_mask[c] = (c >= int'(ptr_eff));
    end
  end

  // Two-pass scan: lowest valid at or above the pointer, else lowest valid overall.
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    idx_lo = '0;
    idx_hi = '0;
    for (int c = int'(LAST_CH); c >= 0; c--) begin
      if (in_valid[c]) begin
        any_lo = 1'b1;
        idx_lo = SEL_W'(c);
      end
      if (in_valid[c] && hi_mask[c]) begin
        any_hi = 1'b1;
        idx_hi = SEL_W'(c);
      end
    end
  end

  assign grant_vld = any_lo;
  assign grant_idx = any_hi ? idx_hi : idx_lo;

  always_comb begin
    grant_oh = '0;
    if (grant_vld) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign in_ready = (load_en && !rst) ? grant_oh : '0;
  assign in_xfer  = grant_vld && load_en && !rst;
  assign ptr_next = (grant_idx == SEL_W'(LAST_CH)) ? '0 : grant_idx + SEL_W'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant_idx];
        out_sel   <= grant_idx;
        if (RR_MODE != 0) begin
          rr_ptr <= ptr_next;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-to-1 registered stream multiplexer with valid/ready handshake on every channel and on the output.
- Selects among competing sources using round-robin or fixed-priority arbitration.
- Holds the winning word in a single output register.
- Sits in the CPU datapath wherever several producers share one consumer, e.g. writeback-source merge or memory-request merge.

Parameters:
- DATA_WIDTH, 16, width of each data word.
- NUM_CH, 4, number of input channels; legal range 2..16.
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SEL_W, $clog2(NUM_CH), width of the channel index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_CH  per-channel valid; bit k belongs to channel k.
- in_data  input  NUM_CH*DATA_WIDTH  packed channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_CH  per-channel ready; at most one bit high in any cycle.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_WIDTH  registered data word.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is combinationally 0 while rst=1.
  - Reset mid-transfer drops the held word; no handshake completes in the reset cycle.
- Output register capacity is one word.
  - load_en = !out_valid || out_ready.
  - Back-to-back throughput is one word per cycle when out_ready stays high.
- Arbitration is combinational and evaluated every cycle over in_valid.
  - RR_MODE=1: winner is the first valid channel scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
  - RR_MODE=0: winner is the lowest-index valid channel; rr_ptr is ignored.
  - No valid channel means no winner.
- in_ready[g]=1 only for winner g, and only when load_en=1 and rst=0. All other bits are 0.
  - in_ready must not depend on in_data.
  - in_ready depends on in_valid only through the arbiter.
- Input transfer on channel g occurs when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - RR_MODE=1: rr_ptr <= (g+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
- Output transfer occurs when out_valid && out_ready.
  - If there is no simultaneous input transfer: out_valid <= 0, and out_data/out_sel hold their last values.
- Simultaneous output and input transfer in the same cycle: the register reloads with the new word and out_valid stays 1 (no bubble).
- Stall (out_valid=1, out_ready=0):
  - out_data, out_sel, out_valid and rr_ptr hold.
  - in_ready=0 on all channels.
- rr_ptr changes only on an input transfer; idle cycles do not advance it.
- Latency: one cycle from input handshake to out_valid.
- Sources must keep in_valid/in_data stable until their transfer. The block does not check this.
- If a source deasserts in_valid before being granted, the arbiter re-evaluates in the same cycle. No transfer occurs for that channel.
- The output side obeys the valid/ready rule: once out_valid=1, out_data and out_sel are stable until out_ready=1.

Test Plan:
1. Reset: apply rst=1 for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0x0000, out_sel=0 throughout. The first release cycle grants channel 0.
2. Round-robin fairness (RR_MODE=1, NUM_CH=4): hold in_valid=1111 and out_ready=1, with channel k driving 0x1000+k.
   - out_sel sequence is 0,1,2,3,0,1..., one word per cycle.
   - out_data is 0x1000, 0x1001, 0x1002, 0x1003, 0x1000...
3. Fixed priority (RR_MODE=0): in_valid=0110 held, out_ready=1 -> channel 1 wins every cycle and channel 2 never gets in_ready. Dropping bit 1 lets channel 2 win on the following cycle.
4. Backpressure: load 0xBEEF from channel 3, then hold out_ready=0 for 5 cycles while in_valid=1111.
   - out_data stays 0xBEEF, out_sel=3, in_ready=0000.
   - After out_ready=1, the next grant is channel 0 (pointer wrapped from 3).
5. Pointer skip: rr_ptr=1, in_valid=1001 -> channel 3 granted, then rr_ptr=0. With in_valid=1001 still held, channel 0 is granted next.
6. Reset mid-stall: out_valid=1 holding 0x55AA, assert rst for 1 cycle -> out_valid=0, out_data=0x0000, rr_ptr=0. The held word is never presented again.
